store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- In-order FIFO of pending stores between the MEM stage and write port 1 of the byte-addressed data memory.
- Accepts stores from the CPU and retires them one per cycle when the memory port is granted.
- Flags any load whose byte range overlaps a buffered store, so the pipeline stalls until that store retires.
- Store/load type encodings are the `STORE_*` / `LOAD_*` codes from defs.h.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).
- ADDR_W, 64, address width.
- DATA_W, 64, data width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset, sampled on posedge clock.
- st_valid  in  1  CPU presents a store this cycle.
- st_ready  out  1  buffer can accept a store.
- st_addr  in  ADDR_W  store byte address.
- st_data  in  DATA_W  store data, right-aligned.
- st_type  in  4  `STORE_BYTE/HALFWORD/WORD/DOUBLEWORD`.
- ld_req  in  1  CPU load in MEM stage.
- ld_addr  in  ADDR_W  load byte address.
- ld_type  in  4  `LOAD_*` code.
- ld_hazard  out  1  load overlaps a buffered store; CPU must stall.
- mem_grant  in  1  write port 1 is free this cycle.
- mem_write_en  out  1  drives MemWriteEn1.
- mem_addr  out  ADDR_W  drives AddressBus1 on drain.
- mem_data  out  DATA_W  drives DataMemoryInput1.
- mem_storetype  out  4  drives storetype1.
- count  out  PTR_W+1  occupied entries.

Behaviour:
- Storage: DEPTH entries of {addr, data, type}, plus head ptr, tail ptr and count, all registered.
- Reset:
  - head = tail = count = 0; entries invalidated.
  - st_ready = 1, ld_hazard = 0, mem_write_en = 0, mem_addr/mem_data/mem_storetype = 0.
  - Reset mid-drain drops all pending stores with no write issued; no partial write.
- Push:
  - Fires when st_valid && st_ready; entry written at tail, tail++ (mod DEPTH).
  - st_ready = (count != DEPTH), from registered count only.
  - When full, a same-cycle drain does not open a slot.
- Drain:
  - Fires when count != 0 && mem_grant.
  - mem_write_en = 1; mem_addr/mem_data/mem_storetype = head entry (combinational from registers).
  - head++ at the clock edge.
  - Otherwise mem_write_en = 0 and the mem_* data outputs are 0.
- Latency: a pushed store is drainable no earlier than the next cycle. Empty + push + grant in the same cycle gives no write.
- Simultaneous push and drain: count unchanged; pointers both advance.
- Wrap-around: pointers wrap mod DEPTH; FIFO order is preserved across the wrap.
- Sizes:
  - Store sizes: BYTE 1, HALFWORD 2, WORD 4, DOUBLEWORD 8.
  - Load sizes: signed and unsigned variants share the same size.
  - Unknown type has size 0: never overlaps, still drains with its type unchanged.
- Overlap: store range [a, a+s-1] intersects load range [b, b+t-1]. Use full ADDR_W compare with ADDR_W+1-bit end sums, so no false match at the top-of-address wrap.
- ld_hazard = ld_req && any valid entry overlaps.
  - Combinational.
  - Includes the entry draining this cycle.
  - Excludes the store pushed this cycle.
- count = number of valid entries, 0..DEPTH.

Optional Feature:
- Macro: STORE_BUF_FORWARD_EN.
- Enabled: adds outputs ld_fwd_valid (1) and ld_fwd_data (DATA_W).
  - Forwarding applies when the youngest overlapping entry has addr == ld_addr and size == load size.
  - In that case: ld_fwd_valid = 1, ld_hazard = 0.
  - ld_fwd_data = entry data, truncated to the load size and sign- or zero-extended per ld_type, matching the memory's extension rules.
  - Any other overlap still raises ld_hazard with ld_fwd_valid = 0.
- Disabled: ports absent; every overlap raises ld_hazard.

Test Plan:
- Reset, then push SD addr 0x10 data 0x1122334455667788 with mem_grant = 0 for 3 cycles → count = 1, mem_write_en = 0. Raise grant → one cycle of mem_write_en = 1, addr 0x10, type `STORE_DOUBLEWORD`; count → 0.
- Push 4 stores with grant = 0 → count = 4, st_ready = 0. A 5th st_valid is ignored. Grant + push in the same cycle → drain only, count = 3.
- Alternate 10 push/drain pairs so the pointers wrap twice → mem_addr sequence equals push order exactly.
- Buffered SB 0x23; LW 0x20 → ld_hazard = 1. LW 0x24 → ld_hazard = 0. LD 0x1C → ld_hazard = 1.
- With STORE_BUF_FORWARD_EN, buffered SH 0x40 data 0x8001; LH 0x40 → ld_fwd_valid = 1, data 0xFFFFFFFFFFFF8001. LHU → 0x8001. LW 0x40 → ld_hazard = 1.
- Assert rst with 3 entries pending and grant = 1 → no write on the reset cycle; count = 0, st_ready = 1 after.

Source files
------------

// File: rtl/store_buffer.sv
// In-order store buffer between MEM and data-memory write port 1, with load-overlap hazard detection.
// Drain is combinational from registers; the optional STORE_BUF_FORWARD_EN macro adds exact-match store-to-load forwarding.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [3:0]        st_type,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [3:0]        ld_type,
    output logic              ld_hazard,
    input  logic              mem_grant,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [3:0]        mem_storetype,
    output logic [PTR_W:0]    count
`ifdef STORE_BUF_FORWARD_EN
    ,
    output logic              ld_fwd_valid,
    output logic [DATA_W-1:0] ld_fwd_data
`endif
);
    localparam logic [3:0] STORE_BYTE       = 4'd1;
    localparam logic [3:0] STORE_HALFWORD   = 4'd2;
    localparam logic [3:0] STORE_WORD       = 4'd3;
    localparam logic [3:0] STORE_DOUBLEWORD = 4'd4;
    localparam logic [3:0] LOAD_BYTE        = 4'd1;
    localparam logic [3:0] LOAD_HALFWORD    = 4'd2;
    localparam logic [3:0] LOAD_WORD        = 4'd3;
    localparam logic [3:0] LOAD_DOUBLEWORD  = 4'd4;
    localparam logic [3:0] LOAD_BYTE_U      = 4'd5;
    localparam logic [3:0] LOAD_HALFWORD_U  = 4'd6;
    localparam logic [3:0] LOAD_WORD_U      = 4'd7;

    function automatic logic [3:0] storeSize(input logic [3:0] t);
        case (t)
            STORE_BYTE:       storeSize = 4'd1;
            STORE_HALFWORD:   storeSize = 4'd2;
            STORE_WORD:       storeSize = 4'd4;
            STORE_DOUBLEWORD: storeSize = 4'd8;
            default:          storeSize = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] loadSize(input logic [3:0] t);
        case (t)
            LOAD_BYTE, LOAD_BYTE_U:         loadSize = 4'd1;
            LOAD_HALFWORD, LOAD_HALFWORD_U: loadSize = 4'd2;
            LOAD_WORD, LOAD_WORD_U:         loadSize = 4'd4;
            LOAD_DOUBLEWORD:                loadSize = 4'd8;
            default:                        loadSize = 4'd0;
        endcase
    endfunction

    logic [ADDR_W-1:0] entryAddr [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];
    logic [3:0]        entryType [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [PTR_W:0]    cnt;
    logic              doPush, doDrain;

    assign st_ready = (cnt != (PTR_W+1)'(DEPTH));
    assign count    = cnt;
    assign doPush   = !rst && st_valid && st_ready;
    assign doDrain  = !rst && (cnt != '0) && mem_grant;

    always_ff @(posedge clock) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entryAddr[i] <= '0;
                entryData[i] <= '0;
                entryType[i] <= '0;
            end
        end else begin
            if (doPush) begin
                entryAddr[tail] <= st_addr;
                entryData[tail] <= st_data;
                entryType[tail] <= st_type;
                tail            <= tail + 1'b1;
            end
            if (doDrain) head <= head + 1'b1;
            case ({doPush, doDrain})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_comb begin
        mem_write_en  = 1'b0;
        mem_addr      = '0;
        mem_data      = '0;
        mem_storetype = '0;
        if (doDrain) begin
            mem_write_en  = 1'b1;
            mem_addr      = entryAddr[head];
            mem_data      = entryData[head];
            mem_storetype = entryType[head];
        end
    end

    // Ranges are compared as half-open intervals in ADDR_W+1 bits so the top of memory never wraps to 0.
    logic [3:0]        ldSz, stSz;
    logic [ADDR_W:0]   ldEnd, stEnd;
    logic [PTR_W-1:0]  idx;
    logic              anyHit;
`ifdef STORE_BUF_FORWARD_EN
    logic [PTR_W-1:0]  youngIdx;
`endif

    always_comb begin
        ldSz   = loadSize(ld_type);
        ldEnd  = {1'b0, ld_addr} + (ADDR_W+1)'(ldSz);
        stSz   = '0;
        stEnd  = '0;
        idx    = '0;
        anyHit = 1'b0;
`ifdef STORE_BUF_FORWARD_EN
        youngIdx = '0;
`endif
        // Walk oldest to youngest so the last hit is the youngest overlapping store.
        for (int k = 0; k < DEPTH; k++) begin
            idx   = head + PTR_W'(k);
            stSz  = storeSize(entryType[idx]);
            stEnd = {1'b0, entryAddr[idx]} + (ADDR_W+1)'(stSz);
            if (((PTR_W+1)'(k) < cnt) && (stSz != 0) && (ldSz != 0) &&
                ({1'b0, entryAddr[idx]} < ldEnd) && ({1'b0, ld_addr} < stEnd)) begin
                anyHit = 1'b1;
`ifdef STORE_BUF_FORWARD_EN
                youngIdx = idx;
`endif
            end
        end
    end

`ifdef STORE_BUF_FORWARD_EN
    logic              fwdMatch;
    logic              ldSigned;
    logic [DATA_W-1:0] fwdSrc;

    assign ldSigned = (ld_type == LOAD_BYTE) || (ld_type == LOAD_HALFWORD) || (ld_type == LOAD_WORD);
    assign fwdSrc   = entryData[youngIdx];
    assign fwdMatch = anyHit && (entryAddr[youngIdx] == ld_addr) &&
                      (storeSize(entryType[youngIdx]) == ldSz);

    always_comb begin
        ld_fwd_valid = !rst && ld_req && fwdMatch;
        ld_hazard    = !rst && ld_req && anyHit && !fwdMatch;
        ld_fwd_data  = '0;
        if (ld_fwd_valid) begin
            case (ldSz)
                4'd1:    ld_fwd_data = {{(DATA_W-8){ldSigned & fwdSrc[7]}}, fwdSrc[7:0]};
                4'd2:    ld_fwd_data = {{(DATA_W-16){ldSigned & fwdSrc[15]}}, fwdSrc[15:0]};
                4'd4:    ld_fwd_data = {{(DATA_W-32){ldSigned & fwdSrc[31]}}, fwdSrc[31:0]};
                default: ld_fwd_data = fwdSrc;
            endcase
        end
    end
`else
    assign ld_hazard = !rst && ld_req && anyHit;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
    localparam logic [3:0] SB = 4'd1, SH = 4'd2, SW = 4'd3, SD = 4'd4;
    localparam logic [3:0] LB = 4'd1, LH = 4'd2, LW = 4'd3, LD = 4'd4;
    localparam logic [3:0] LBU = 4'd5, LHU = 4'd6, LWU = 4'd7;

    logic        clock = 1'b0;
    logic        rst, st_valid, st_ready, ld_req, ld_hazard, mem_grant, mem_write_en;
    logic [63:0] st_addr, st_data, ld_addr, mem_addr, mem_data;
    logic [3:0]  st_type, ld_type, mem_storetype;
    logic [2:0]  count;
`ifdef STORE_BUF_FORWARD_EN
    logic        ld_fwd_valid;
    logic [63:0] ld_fwd_data;
`endif

    always #5 clock = ~clock;

    store_buffer dut (
        .clock(clock), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_type(ld_type), .ld_hazard(ld_hazard),
        .mem_grant(mem_grant), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_storetype(mem_storetype), .count(count)
`ifdef STORE_BUF_FORWARD_EN
        , .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [3:0]  typ;
    } entry_t;
    entry_t model[$];

    int checkCnt = 0;
    int passCnt  = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        if (obs === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int stSize(input logic [3:0] t);
        case (t)
            SB: return 1;
            SH: return 2;
            SW: return 4;
            SD: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int ldSize(input logic [3:0] t);
        case (t)
            LB, LBU: return 1;
            LH, LHU: return 2;
            LW, LWU: return 4;
            LD:      return 8;
            default: return 0;
        endcase
    endfunction

    // Byte-by-byte intersection on 65-bit addresses: no wrap past the top of memory.
    function automatic bit overlaps(input entry_t e, input logic [63:0] la, input logic [3:0] lt);
        logic [64:0] sa, lb;
        for (int i = 0; i < stSize(e.typ); i++) begin
            sa = {1'b0, e.addr} + 65'(i);
            for (int j = 0; j < ldSize(lt); j++) begin
                lb = {1'b0, la} + 65'(j);
                if (sa == lb) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] d, input logic [3:0] lt);
        int sh;
        logic [63:0] tmp;
        sh  = 64 - 8 * ldSize(lt);
        tmp = d << sh;
        if (lt == LB || lt == LH || lt == LW) return $unsigned($signed(tmp) >>> sh);
        return tmp >> sh;
    endfunction

    task automatic drive(input logic r, input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                         input logic [3:0] stt, input logic lr, input logic [63:0] la,
                         input logic [3:0] lt, input logic g);
        bit expWen, expHaz, expFwd, anyOv;
        int young;
        logic [63:0] expFwdData;
        @(negedge clock);
        rst = r; st_valid = sv; st_addr = sa; st_data = sd; st_type = stt;
        ld_req = lr; ld_addr = la; ld_type = lt; mem_grant = g;
        #1;
        expWen = !r && g && (model.size() != 0);
        checkVal("st_ready", 64'(st_ready), 64'(model.size() != 4));
        checkVal("count", 64'(count), 64'(model.size()));
        checkVal("mem_write_en", 64'(mem_write_en), 64'(expWen));
        checkVal("mem_addr", mem_addr, expWen ? model[0].addr : 64'h0);
        checkVal("mem_data", mem_data, expWen ? model[0].data : 64'h0);
        checkVal("mem_storetype", 64'(mem_storetype), expWen ? 64'(model[0].typ) : 64'h0);
        anyOv = 1'b0;
        young = -1;
        foreach (model[i]) if (overlaps(model[i], la, lt)) begin anyOv = 1'b1; young = i; end
        expFwd = 1'b0;
        expFwdData = 64'h0;
`ifdef STORE_BUF_FORWARD_EN
        if (!r && lr && young >= 0 && model[young].addr == la &&
            stSize(model[young].typ) == ldSize(lt)) begin
            expFwd = 1'b1;
            expFwdData = extend(model[young].data, lt);
        end
        checkVal("ld_fwd_valid", 64'(ld_fwd_valid), 64'(expFwd));
        checkVal("ld_fwd_data", ld_fwd_data, expFwdData);
`endif
        expHaz = !r && lr && anyOv && !expFwd;
        checkVal("ld_hazard", 64'(ld_hazard), 64'(expHaz));
    endtask

    task automatic tick();
        bit canPush, drainNow;
        entry_t e;
        @(posedge clock);
        if (rst) begin
            model.delete();
        end else begin
            canPush  = model.size() < 4;
            drainNow = mem_grant && model.size() != 0;
            if (drainNow) void'(model.pop_front());
            if (st_valid && canPush) begin
                e.addr = st_addr; e.data = st_data; e.typ = st_type;
                model.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic g);
        drive(1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 1'b0, 64'h0, 4'h0, g);
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [3:0] t, input logic g);
        drive(1'b0, 1'b1, a, d, t, 1'b0, 64'h0, 4'h0, g);
    endtask

    task automatic load(input logic [63:0] a, input logic [3:0] t);
        drive(1'b0, 1'b0, 64'h0, 64'h0, 4'h0, 1'b1, a, t, 1'b0);
    endtask

    logic [63:0] pushed[$];
    logic [63:0] ra, rl;

    initial begin
        drive(1'b1, 1'b0, 64'h0, 64'h0, 4'h0, 1'b0, 64'h0, 4'h0, 1'b0); tick();
        drive(1'b1, 1'b0, 64'h0, 64'h0, 4'h0, 1'b0, 64'h0, 4'h0, 1'b0); tick();
        idle(1'b0);
        checkVal("reset count", 64'(count), 64'd0);
        checkVal("reset st_ready", 64'(st_ready), 64'd1);
        tick();

        // Single doubleword store held until grant.
        push(64'h10, 64'h1122334455667788, SD, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            checkVal("held count", 64'(count), 64'd1);
            checkVal("held wen", 64'(mem_write_en), 64'd0);
            tick();
        end
        idle(1'b1);
        checkVal("drain wen", 64'(mem_write_en), 64'd1);
        checkVal("drain addr", mem_addr, 64'h10);
        checkVal("drain type", 64'(mem_storetype), 64'(SD));
        tick();
        idle(1'b1);
        checkVal("drained count", 64'(count), 64'd0);
        checkVal("drained wen", 64'(mem_write_en), 64'd0);
        tick();

        // Empty + push + grant gives no write that cycle.
        push(64'h18, 64'hAB, SB, 1'b1);
        checkVal("empty push grant wen", 64'(mem_write_en), 64'd0);
        tick();
        idle(1'b1); tick();

        // Fill, refuse a fifth, then full + grant + push drains only.
        for (int i = 0; i < 4; i++) begin push(64'h100 + 64'(8 * i), 64'(i), SD, 1'b0); tick(); end
        idle(1'b0);
        checkVal("full count", 64'(count), 64'd4);
        checkVal("full st_ready", 64'(st_ready), 64'd0);
        tick();
        push(64'h200, 64'h5, SD, 1'b0); tick();
        push(64'h208, 64'h6, SD, 1'b1);
        checkVal("full drain addr", mem_addr, 64'h100);
        tick();
        idle(1'b0);
        checkVal("full drain count", 64'(count), 64'd3);
        tick();
        for (int i = 0; i < 3; i++) begin idle(1'b1); tick(); end

        // Push/drain pairs wrap both pointers twice.
        for (int i = 0; i < 10; i++) begin
            push(64'h300 + 64'(i * 4), 64'(i), SW, 1'b0);
            pushed.push_back(64'h300 + 64'(i * 4));
            tick();
            idle(1'b1);
            checkVal("wrap order", mem_addr, pushed.pop_front());
            tick();
        end

        // Overlap detection around a buffered byte store at 0x23.
        push(64'h23, 64'h5A, SB, 1'b0); tick();
        load(64'h20, LW); checkVal("SB23 LW20 hazard", 64'(ld_hazard), 64'd1); tick();
        load(64'h24, LW); checkVal("SB23 LW24 hazard", 64'(ld_hazard), 64'd0); tick();
        load(64'h1C, LD); checkVal("SB23 LD1C hazard", 64'(ld_hazard), 64'd1); tick();
        idle(1'b1); tick();

`ifdef STORE_BUF_FORWARD_EN
        push(64'h40, 64'h8001, SH, 1'b0); tick();
        load(64'h40, LH);
        checkVal("LH fwd valid", 64'(ld_fwd_valid), 64'd1);
        checkVal("LH fwd data", ld_fwd_data, 64'hFFFFFFFFFFFF8001);
        tick();
        load(64'h40, LHU); checkVal("LHU fwd data", ld_fwd_data, 64'h8001); tick();
        load(64'h40, LW);  checkVal("LW no fwd hazard", 64'(ld_hazard), 64'd1); tick();
        idle(1'b1); tick();
`endif

        // Top-of-address store must not alias low addresses.
        push(64'hFFFFFFFFFFFFFFFC, 64'h1, SD, 1'b0); tick();
        load(64'h0, LD); checkVal("top wrap hazard", 64'(ld_hazard), 64'd0); tick();
        idle(1'b1); tick();

        // Reset with pending stores and grant issues no write.
        for (int i = 0; i < 3; i++) begin push(64'h500 + 64'(i), 64'(i), SB, 1'b0); tick(); end
        drive(1'b1, 1'b0, 64'h0, 64'h0, 4'h0, 1'b0, 64'h0, 4'h0, 1'b1);
        checkVal("reset-cycle wen", 64'(mem_write_en), 64'd0);
        tick();
        idle(1'b1);
        checkVal("post-reset count", 64'(count), 64'd0);
        checkVal("post-reset st_ready", 64'(st_ready), 64'd1);
        tick();

        // Random traffic with clustered addresses so overlaps are frequent.
        for (int n = 0; n < 600; n++) begin
            ra = ($urandom_range(0, 15) == 0) ? 64'hFFFFFFFFFFFFFFF0 + 64'($urandom_range(0, 15))
                                              : 64'($urandom_range(0, 63));
            rl = ($urandom_range(0, 15) == 0) ? 64'hFFFFFFFFFFFFFFF0 + 64'($urandom_range(0, 15))
                                              : 64'($urandom_range(0, 63));
            drive(($urandom_range(0, 99) == 0), 1'($urandom), ra, {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4)),
                  1'($urandom), rl, 4'($urandom_range(0, 8)), ($urandom_range(0, 2) != 0));
            tick();
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
